// File: rtl/maze_player_ctrl_pkg.sv
// Shared definitions for the maze player controller.
//   DEF_GRID  : default maze dimension (tiles per row/column)
//   COORD_W   : width of every tile coordinate port
//   dir_e     : latched step direction
//   state_e   : controller FSM states
package maze_player_ctrl_pkg;

  localparam int DEF_GRID = 16;
  localparam int COORD_W  = 7;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_HOLD  = 2'd2,
    ST_WON   = 2'd3
  } state_e;

endpackage

// File: rtl/maze_player_ctrl_btn_sync_edge.sv
// Two-flop synchronizer for one raw push button plus rising-edge detect.
//   clk, reset : system clock, asynchronous active-high reset
//   btn_in     : raw asynchronous button
//   btn_sync   : synchronized level
//   btn_rise   : high for one cycle when the synchronized level goes 0->1
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_sync,
  output logic btn_rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = btn_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign btn_sync = sync_q;
  assign btn_rise = sync_q & ~prev_q;

endmodule

// File: rtl/maze_player_ctrl.sv
// Maze player controller: turns four direction buttons into the character
// tile position, refusing steps into walls or off the active maze area.
//   clk, reset             : system clock, asynchronous active-high reset
//   enable                 : movement permitted when high
//   load                   : place character at start, clear move counter
//   btn_up/down/left/right : raw buttons, active-high
//   path_data              : GRID*GRID bitmap, 1 = open tile (x + GRID*y)
//   maze_width/height      : active maze size in tiles
//   start_x/y, goal_x/y    : start and goal tiles
//   char_x/y               : current character tile
//   moved / blocked        : one-cycle pulse for an accepted / refused step
//   at_goal                : character sits on the goal tile
//   move_count             : accepted steps since load, saturating
module maze_player_ctrl
  import maze_player_ctrl_pkg::*;
#(
  parameter int GRID         = DEF_GRID,
  parameter int REPEAT_DELAY = 12_500_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   load,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic [GRID*GRID-1:0]   path_data,
  input  logic [COORD_W-1:0]     maze_width,
  input  logic [COORD_W-1:0]     maze_height,
  input  logic [COORD_W-1:0]     start_x,
  input  logic [COORD_W-1:0]     start_y,
  input  logic [COORD_W-1:0]     goal_x,
  input  logic [COORD_W-1:0]     goal_y,
  output logic [COORD_W-1:0]     char_x,
  output logic [COORD_W-1:0]     char_y,
  output logic                   moved,
  output logic                   blocked,
  output logic                   at_goal,
  output logic [15:0]            move_count
);

  localparam int MAX_WAIT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TIMER_W  = $clog2(MAX_WAIT + 1);
  localparam int IDX_W    = $clog2(GRID * GRID);

  // Button synchronizers, indexed by dir_e value.
  logic [3:0] btn_raw;
  logic [3:0] btn_sync;
  logic [3:0] btn_rise;

  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    btn_sync_edge u_sync (
      .clk      (clk),
      .reset    (reset),
      .btn_in   (btn_raw[gi]),
      .btn_sync (btn_sync[gi]),
      .btn_rise (btn_rise[gi])
    );
  end

  state_e               state_q, state_d;
  dir_e                 dir_q, dir_d;
  logic [COORD_W-1:0]   char_x_q, char_x_d;
  logic [COORD_W-1:0]   char_y_q, char_y_d;
  logic                 moved_q, moved_d;
  logic                 blocked_q, blocked_d;
  logic [15:0]          move_count_q, move_count_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 repeat_q, repeat_d;   // an auto-repeat already fired in this hold

  // Step target, one bit wider than a coordinate so x+1 never wraps.
  logic [7:0]           tgt_x, tgt_y;
  logic                 underflow;
  logic                 in_bounds;
  logic                 step_legal;
  logic [IDX_W-1:0]     path_idx;
  dir_e                 rise_dir;
  logic [TIMER_W-1:0]   timer_inc;
  logic [TIMER_W-1:0]   hold_limit;

  always_comb begin
    tgt_x     = {1'b0, char_x_q};
    tgt_y     = {1'b0, char_y_q};
    underflow = 1'b0;
    case (dir_q)
      DIR_UP: begin
        if (char_y_q == '0) underflow = 1'b1;
        else                tgt_y = tgt_y - 8'd1;
      end
      DIR_DOWN:  tgt_y = tgt_y + 8'd1;
      DIR_LEFT: begin
        if (char_x_q == '0) underflow = 1'b1;
        else                tgt_x = tgt_x - 8'd1;
      end
      DIR_RIGHT: tgt_x = tgt_x + 8'd1;
      default:   underflow = 1'b1;
    endcase

    in_bounds = !underflow
             && (tgt_x < {1'b0, maze_width}) && (tgt_y < {1'b0, maze_height})
             && (tgt_x < 8'(GRID)) && (tgt_y < 8'(GRID));
    // Index only formed for in-range targets so it never exceeds the bitmap.
    path_idx   = in_bounds ? IDX_W'(int'(tgt_x) + GRID * int'(tgt_y)) : '0;
    step_legal = in_bounds && path_data[path_idx];
  end

  // Fixed priority: up > down > left > right.
  always_comb begin
    if      (btn_rise[DIR_UP])   rise_dir = DIR_UP;
    else if (btn_rise[DIR_DOWN]) rise_dir = DIR_DOWN;
    else if (btn_rise[DIR_LEFT]) rise_dir = DIR_LEFT;
    else                         rise_dir = DIR_RIGHT;
  end

  // HOLD lasts limit-1 cycles and CHECK one more, so accepted steps are
  // spaced exactly REPEAT_DELAY (first) / REPEAT_RATE (later) cycles apart.
  assign timer_inc  = timer_q + TIMER_W'(1);
  assign hold_limit = repeat_q ? TIMER_W'(REPEAT_RATE - 1) : TIMER_W'(REPEAT_DELAY - 1);

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    char_x_d     = char_x_q;
    char_y_d     = char_y_q;
    moved_d      = 1'b0;
    blocked_d    = 1'b0;
    move_count_d = move_count_q;
    timer_d      = timer_q;
    repeat_d     = repeat_q;

    if (load) begin
      state_d      = ST_IDLE;
      char_x_d     = start_x;
      char_y_d     = start_y;
      move_count_d = '0;
      timer_d      = '0;
      repeat_d     = 1'b0;
    end else if (!enable && state_q != ST_WON) begin
      // Discards any CHECK in flight without a pulse.
      state_d = ST_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|btn_rise) begin
            dir_d    = rise_dir;
            state_d  = ST_CHECK;
            repeat_d = 1'b0;
          end
        end
        ST_CHECK: begin
          timer_d = '0;
          if (step_legal) begin
            char_x_d = tgt_x[COORD_W-1:0];
            char_y_d = tgt_y[COORD_W-1:0];
            moved_d  = 1'b1;
            if (move_count_q != 16'hFFFF) move_count_d = move_count_q + 16'd1;
            if (tgt_x[COORD_W-1:0] == goal_x && tgt_y[COORD_W-1:0] == goal_y)
              state_d = ST_WON;
            else
              state_d = ST_HOLD;
          end else begin
            blocked_d = 1'b1;
            state_d   = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!btn_sync[dir_q]) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else if (timer_inc == hold_limit) begin
            state_d  = ST_CHECK;
            timer_d  = '0;
            repeat_d = 1'b1;
          end else begin
            timer_d = timer_inc;
          end
        end
        ST_WON: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      dir_q        <= DIR_UP;
      char_x_q     <= '0;
      char_y_q     <= '0;
      moved_q      <= 1'b0;
      blocked_q    <= 1'b0;
      move_count_q <= '0;
      timer_q      <= '0;
      repeat_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      char_x_q     <= char_x_d;
      char_y_q     <= char_y_d;
      moved_q      <= moved_d;
      blocked_q    <= blocked_d;
      move_count_q <= move_count_d;
      timer_q      <= timer_d;
      repeat_q     <= repeat_d;
    end
  end

  assign char_x     = char_x_q;
  assign char_y     = char_y_q;
  assign moved      = moved_q;
  assign blocked    = blocked_q;
  assign at_goal    = (state_q == ST_WON);
  assign move_count = move_count_q;

endmodule

// File: tb/tb_maze_player_ctrl.sv
module tb_maze_player_ctrl;

  localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable, load;
  logic         btn_up, btn_down, btn_left, btn_right;
  logic [255:0] path_data;
  logic [6:0]   maze_width, maze_height, start_x, start_y, goal_x, goal_y;
  logic [6:0]   char_x, char_y;
  logic         moved, blocked, at_goal;
  logic [15:0]  move_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    bit          is_block;
    logic [6:0]  x;
    logic [6:0]  y;
    logic [15:0] cnt;
    bit          goal;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  maze_player_ctrl #(
    .GRID         (16),
    .REPEAT_DELAY (10),
    .REPEAT_RATE  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .load        (load),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .path_data   (path_data),
    .maze_width  (maze_width),
    .maze_height (maze_height),
    .start_x     (start_x),
    .start_y     (start_y),
    .goal_x      (goal_x),
    .goal_y      (goal_y),
    .char_x      (char_x),
    .char_y      (char_y),
    .moved       (moved),
    .blocked     (blocked),
    .at_goal     (at_goal),
    .move_count  (move_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every moved/blocked pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && (moved || blocked)) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse cyc=%0d moved=%0b blocked=%0b char=(%0d,%0d) count=%0d",
                 cyc, moved, blocked, char_x, char_y, move_count);
      end else begin
        mon_e = sb.pop_front();
        if (blocked != mon_e.is_block || moved == mon_e.is_block || char_x != mon_e.x ||
            char_y != mon_e.y || move_count != mon_e.cnt || at_goal != mon_e.goal ||
            cyc != mon_e.cyc) begin
          n_fail++;
          $display("FAIL step got moved=%0b blocked=%0b char=(%0d,%0d) count=%0h goal=%0b cyc=%0d required blocked=%0b char=(%0d,%0d) count=%0h goal=%0b cyc=%0d",
                   moved, blocked, char_x, char_y, move_count, at_goal, cyc,
                   mon_e.is_block, mon_e.x, mon_e.y, mon_e.cnt, mon_e.goal, mon_e.cyc);
        end else begin
          $display("step ok: blocked=%0b char=(%0d,%0d) count=%0h goal=%0b cyc=%0d",
                   blocked, char_x, char_y, move_count, at_goal, cyc);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("check %s ok: %0h", name, act);
    end
  endtask

  function automatic int xy(input int x, input int y);
    return x * 128 + y;
  endfunction

  function automatic int char_xy();
    return xy(int'(char_x), int'(char_y));
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic open_tile(input int x, input int y);
    path_data[x + 16 * y] = 1'b1;
  endtask

  task automatic expect_ev(input bit blk, input int x, input int y, input int cnt,
                           input bit g, input int off);
    exp_t e;
    e.is_block = blk;
    e.x        = 7'(x);
    e.y        = 7'(y);
    e.cnt      = 16'(cnt);
    e.goal     = g;
    e.cyc      = cyc + off;
    sb.push_back(e);
  endtask

  task automatic set_btn(input int d, input logic v);
    case (d)
      UP:      btn_up    = v;
      DOWN:    btn_down  = v;
      LEFT:    btn_left  = v;
      default: btn_right = v;
    endcase
  endtask

  task automatic do_load(input int x, input int y);
    start_x = 7'(x);
    start_y = 7'(y);
    load    = 1'b1;
    tick(1);
    load    = 1'b0;
    tick(1);
  endtask

  // Hold a button for 'hold' cycles, then leave time for HOLD to return to IDLE.
  task automatic press(input int d, input int hold);
    set_btn(d, 1'b1);
    tick(hold);
    set_btn(d, 1'b0);
    tick(6);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; load = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    path_data = '0;
    maze_width = 7'd16; maze_height = 7'd16;
    start_x = '0; start_y = '0; goal_x = 7'd15; goal_y = 7'd15;
    tick(3);
    check("reset_char", char_xy(), 0);
    check("reset_flags", int'({moved, blocked, at_goal}), 0);
    check("reset_count", int'(move_count), 0);
    reset = 1'b0;
    tick(2);

    // Single step with latency check.
    path_data = '0; open_tile(1, 1); open_tile(2, 1);
    do_load(1, 1);
    check("load_char", char_xy(), xy(1, 1));
    expect_ev(1'b0, 2, 1, 1, 1'b0, 4);
    btn_right = 1'b1;
    tick(3);
    check("latency_before", int'(char_x), 1);
    tick(1);
    check("latency_after", int'(char_x), 2);
    tick(1);
    btn_right = 1'b0;
    tick(6);
    check("count_one", int'(move_count), 1);

    // Refused steps: underflow, closed tile, beyond maze_width; then a legal step.
    path_data = '0; open_tile(0, 0);
    do_load(0, 0);
    expect_ev(1'b1, 0, 0, 0, 1'b0, 4);
    press(UP, 5);
    expect_ev(1'b1, 0, 0, 0, 1'b0, 4);
    press(DOWN, 5);
    check("blocked_char", char_xy(), xy(0, 0));
    maze_width = 7'd4;
    open_tile(2, 0); open_tile(3, 0); open_tile(4, 0);
    do_load(3, 0);
    expect_ev(1'b1, 3, 0, 0, 1'b0, 4);
    press(RIGHT, 5);
    expect_ev(1'b0, 2, 0, 1, 1'b0, 4);
    press(LEFT, 5);
    check("narrow_char", char_xy(), xy(2, 0));
    maze_width = 7'd16;

    // Hold-to-repeat: steps at offsets 0, 10, 14, 18, 22, 26 after the first.
    path_data = '0;
    for (int x = 0; x < 8; x++) open_tile(x, 0);
    do_load(0, 0);
    expect_ev(1'b0, 1, 0, 1, 1'b0, 4);
    expect_ev(1'b0, 2, 0, 2, 1'b0, 14);
    expect_ev(1'b0, 3, 0, 3, 1'b0, 18);
    expect_ev(1'b0, 4, 0, 4, 1'b0, 22);
    expect_ev(1'b0, 5, 0, 5, 1'b0, 26);
    expect_ev(1'b0, 6, 0, 6, 1'b0, 30);
    press(RIGHT, 30);
    check("repeat_count", int'(move_count), 6);
    check("repeat_char", char_xy(), xy(6, 0));

    // Priority up over left, then goal and WON lockout.
    path_data = '0;
    open_tile(5, 5); open_tile(5, 4); open_tile(4, 5); open_tile(5, 3);
    goal_x = 7'd5; goal_y = 7'd3;
    do_load(5, 5);
    expect_ev(1'b0, 5, 4, 1, 1'b0, 4);
    btn_up = 1'b1; btn_left = 1'b1;
    tick(5);
    btn_up = 1'b0; btn_left = 1'b0;
    tick(6);
    expect_ev(1'b0, 5, 3, 2, 1'b1, 4);
    press(UP, 5);
    press(DOWN, 5);
    check("won_char", char_xy(), xy(5, 3));
    check("won_goal", int'(at_goal), 1);
    check("won_count", int'(move_count), 2);
    do_load(5, 5);
    check("load_clears_goal", int'(at_goal), 0);
    check("load_clears_count", int'(move_count), 0);
    goal_x = 7'd15; goal_y = 7'd15;

    // enable dropped during CHECK: no pulse, nothing moves.
    path_data = '0; open_tile(0, 0); open_tile(1, 0);
    do_load(0, 0);
    btn_right = 1'b1;
    tick(3);
    enable = 1'b0;
    tick(3);
    btn_right = 1'b0;
    tick(4);
    enable = 1'b1;
    tick(2);
    check("disable_char", char_xy(), xy(0, 0));
    check("disable_count", int'(move_count), 0);
    expect_ev(1'b0, 1, 0, 1, 1'b0, 4);
    press(RIGHT, 5);

    // Saturation: preload the counter next to its ceiling.
    force dut.move_count_d = 16'hFFFE;
    tick(1);
    release dut.move_count_d;
    check("preload_count", int'(move_count), 32'hFFFE);
    expect_ev(1'b0, 0, 0, 32'hFFFF, 1'b0, 4);
    press(LEFT, 5);
    expect_ev(1'b0, 1, 0, 32'hFFFF, 1'b0, 4);
    press(RIGHT, 5);
    check("saturated_count", int'(move_count), 32'hFFFF);

    // Asynchronous reset in the middle of a HOLD.
    path_data = '0; open_tile(2, 2); open_tile(3, 2);
    do_load(2, 2);
    expect_ev(1'b0, 3, 2, 1, 1'b0, 4);
    btn_right = 1'b1;
    tick(8);
    #2 reset = 1'b1;
    #1;
    check("async_rst_char", char_xy(), 0);
    check("async_rst_count", int'(move_count), 0);
    check("async_rst_flags", int'({moved, blocked, at_goal}), 0);
    btn_right = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/maze_player_ctrl.md
Name: maze_player_ctrl

Overview:
- Upstream of the maze renderer: converts the four direction buttons into the character tile position (char_x, char_y) that the renderer consumes.
- Checks every requested step against the same 16x16 path bitmap the renderer draws; steps into walls or off the maze are refused.
- Provides hold-to-repeat movement, a move counter, and goal detection for the game-level controller.

Parameters:
- GRID, 16, row stride and maximum dimension of path_data (index = x + GRID*y).
- REPEAT_DELAY, 12_500_000, cycles a button must stay held after a step before the first auto-repeat.
- REPEAT_RATE, 5_000_000, cycles between subsequent auto-repeats.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  movement permitted when high
- load  in  1  one-cycle pulse: place character at start, clear counters
- btn_up, btn_down, btn_left, btn_right  in  1 each  raw asynchronous buttons, active-high
- path_data  in  GRID*GRID  1 = open path tile
- maze_width, maze_height  in  7  active maze size in tiles (1..GRID)
- start_x, start_y, goal_x, goal_y  in  7 each  tile coordinates
- char_x, char_y  out  7 each  current character tile
- moved  out  1  one-cycle pulse on an accepted step
- blocked  out  1  one-cycle pulse on a refused step
- at_goal  out  1  level: character on goal tile (state WON)
- move_count  out  16  accepted steps since load, saturating

Behaviour:
- Reset (async, active-high): char_x = char_y = 0; moved = blocked = at_goal = 0; move_count = 0; state IDLE; repeat timer = 0; synchronizers cleared.
- Button synchronization: each button passes through a 2-flop synchronizer plus a previous-value register. Rising edge = sync high AND prev low.
- Direction priority when several buttons qualify: up > down > left > right. Up = y-1, down = y+1, left = x-1, right = x+1.
- FSM states: IDLE, CHECK, HOLD, WON.
- IDLE: if enable and any rising edge, latch the winning direction and go to CHECK.
- CHECK (one cycle): compute target tile, zero-extended to 8 bits. The step is legal only if:
  - target x < maze_width and target y < maze_height, and both < GRID;
  - decrementing from 0 is illegal (no wrap-around);
  - path_data[tx + GRID*ty] == 1.
- CHECK, legal step: on the next edge update char, pulse moved, increment move_count (holds at 16'hFFFF). If the new char equals the goal, go to WON; otherwise go to HOLD.
- CHECK, illegal step: pulse blocked, char unchanged, go to HOLD.
- HOLD:
  - timer counts up while the latched direction's synchronized button stays high.
  - Timer reaching REPEAT_DELAY-1 (first repeat) or REPEAT_RATE-1 (later repeats) → CHECK, timer cleared.
  - Latched button released → IDLE.
  - Other buttons are ignored while in HOLD.
- WON: at_goal = 1. All buttons are ignored; remains in WON until load or reset.
- load: priority over everything except reset, and over a simultaneous move. Next edge: char = start, move_count = 0, at_goal = 0, state IDLE, timer cleared, moved/blocked = 0.
- enable low: any state except WON goes to IDLE next edge; char and move_count hold; a CHECK in flight is discarded with no pulse.
- Latency: raw button sampled high at edge 0 → state CHECK after edge 2 → char_x/char_y and moved valid after edge 3.
- moved and blocked are never high in the same cycle. Each pulse is exactly one cycle.
- Changing maze_width, maze_height or path_data mid-game takes effect at the next CHECK; the current position is not re-validated.

Decomposition:
- Shared package: GRID constant, 7-bit coordinate width, direction encoding (DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3), FSM state encoding.
- One natural sub-module: btn_sync_edge (2-flop synchronizer plus rising-edge detect), instantiated four times.

Test Plan:
- Reset mid-HOLD (timer nonzero, char=(3,2)) → outputs return to 0 immediately, without waiting for a clock edge.
- load with start=(1,1), path (1,1),(2,1) open; pulse btn_right 5 cycles → char_x=2 exactly 3 edges after first sample; moved pulses once; move_count=1.
- char=(0,0), btn_up → blocked pulse, char stays (0,0). Repeat with target tile path bit = 0 → blocked; with maze_width=4, char x=3, btn_right → blocked.
- REPEAT_DELAY=10, REPEAT_RATE=4, open row 0..7, hold btn_right for 30 cycles after the first step → steps at cycle offsets 0, 10, 14, 18, 22, 26; move_count=6.
- btn_up and btn_left raised on the same edge, both open → moves up only. Goal at target → at_goal=1; further presses ignored; load clears at_goal.
- enable dropped the cycle after CHECK entry → no moved/blocked pulse, char unchanged. Drive move_count to 16'hFFFF → further moves keep it 16'hFFFF.
